// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the CPU / MMU / SRAM side and mem_access_ctrl.
// Byte-lane signals exist only when MEMCTL_BYTE_LANES_EN is defined.
interface mem_access_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic [15:0] mmu_addr;
  logic [17:0] mmu_paddr;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
`ifdef MEMCTL_BYTE_LANES_EN
  logic [1:0]  cpu_be;
  logic        sram_ub_n;
  logic        sram_lb_n;
`endif

  // Controller view.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mmu_paddr, sram_dq_in,
`ifdef MEMCTL_BYTE_LANES_EN
    input  cpu_be,
    output sram_ub_n, sram_lb_n,
`endif
    output cpu_ack, cpu_rdata, cpu_busy, mmu_addr, sram_addr, sram_dq_out,
    output sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  // CPU / MMU / SRAM environment view.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mmu_paddr, sram_dq_in,
`ifdef MEMCTL_BYTE_LANES_EN
    output cpu_be,
    input  sram_ub_n, sram_lb_n,
`endif
    input  cpu_ack, cpu_rdata, cpu_busy, mmu_addr, sram_addr, sram_dq_out,
    input  sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// CPU -> MMU -> async SRAM access sequencer with programmable wait states.
// Optional byte-lane strobes are enabled by defining MEMCTL_BYTE_LANES_EN.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XLATE  = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [1:0]  be_s;
  logic [15:0] rd_mask_s;
  logic        in_access_s;

`ifdef MEMCTL_BYTE_LANES_EN
  logic [1:0]  be_q, be_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;
  assign be_s = be_q;
`else
  assign be_s = 2'b11;
`endif

  assign rd_mask_s = {{8{be_s[1]}}, {8{be_s[0]}}};
  // Held through XLATE so the MMU offset bits stay valid during the lookup.
  assign bus.mmu_addr = (state_q == IDLE) ? bus.cpu_addr : addr_q;

  // Next-state, request latching and registered-output next values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    rdata_d     = rdata_q;
`ifdef MEMCTL_BYTE_LANES_EN
    be_d        = be_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          we_d    = bus.cpu_we;
`ifdef MEMCTL_BYTE_LANES_EN
          be_d    = bus.cpu_be;
`endif
          state_d = XLATE;
        end else begin
          state_d = IDLE;
        end
      end
      XLATE: begin
        sram_addr_d = bus.mmu_paddr;
        dq_out_d    = wdata_q;
        cnt_d       = WAIT_LD;
        state_d     = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            rdata_d = bus.sram_dq_in & rd_mask_s;
          end else begin
            rdata_d = rdata_q;
          end
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes are flops loaded from the next state, so they are glitch-free
    // and the async reset releases them immediately.
    in_access_s = (state_d == ACCESS);
    ce_n_d  = !(in_access_s && (be_s != 2'b00));
    oe_n_d  = !(in_access_s && (be_s != 2'b00) && !we_q);
    we_n_d  = !(in_access_s && (be_s != 2'b00) && we_q);
    dq_oe_d = in_access_s && we_q;
    ack_d   = (state_d == ACK);
    busy_d  = (state_d != IDLE);
`ifdef MEMCTL_BYTE_LANES_EN
    ub_n_d  = !(in_access_s && be_s[1]);
    lb_n_d  = !(in_access_s && be_s[0]);
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      sram_addr_q <= 18'h00000;
      dq_out_q    <= 16'h0000;
      rdata_q     <= 16'h0000;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
`ifdef MEMCTL_BYTE_LANES_EN
      be_q        <= 2'b11;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
`ifdef MEMCTL_BYTE_LANES_EN
      be_q        <= be_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
`endif
    end
  end

  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.cpu_busy    = busy_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;
`ifdef MEMCTL_BYTE_LANES_EN
  assign bus.sram_ub_n   = ub_n_q;
  assign bus.sram_lb_n   = lb_n_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three instances with WAIT_STATES 1, 0, 15.
// Cycle counts n are edges after the request-sampling edge E; ack seen after edge E+n.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        req_i   [3];
  logic        we_i    [3];
  logic [15:0] addr_i  [3];
  logic [15:0] wdata_i [3];
  logic [15:0] din_i   [3];
  logic        ack_o   [3];
  logic        busy_o  [3];
  logic        ce_o    [3];
  logic        oe_o    [3];
  logic        wen_o   [3];
  logic        dqoe_o  [3];
  logic [15:0] rdata_o [3];
  logic [15:0] dqout_o [3];
  logic [17:0] saddr_o [3];
  logic [15:0] mmua_o  [3];
`ifdef MEMCTL_BYTE_LANES_EN
  logic [1:0]  be_i    [3];
  logic        ub_o    [3];
  logic        lb_o    [3];
`endif

  // Page table: page 1 -> frame 0x25, page 31 -> frame 0x7F, others identity.
  function automatic logic [17:0] xlate(input logic [15:0] va);
    logic [6:0] frame;
    case (va[15:11])
      5'd1:    frame = 7'h25;
      5'd31:   frame = 7'h7F;
      default: frame = {2'b00, va[15:11]};
    endcase
    return {frame, va[10:0]};
  endfunction

  mem_access_ctrl_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [17:0] paddr_q;
    mem_access_ctrl #(.WAIT_STATES(g == 0 ? 1 : (g == 1 ? 0 : 15))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
    always @(posedge clk) paddr_q <= xlate(bus[g].mmu_addr);
    assign bus[g].mmu_paddr  = paddr_q;
    assign bus[g].cpu_req    = req_i[g];
    assign bus[g].cpu_we     = we_i[g];
    assign bus[g].cpu_addr   = addr_i[g];
    assign bus[g].cpu_wdata  = wdata_i[g];
    assign bus[g].sram_dq_in = din_i[g];
    assign ack_o[g]   = bus[g].cpu_ack;
    assign busy_o[g]  = bus[g].cpu_busy;
    assign ce_o[g]    = bus[g].sram_ce_n;
    assign oe_o[g]    = bus[g].sram_oe_n;
    assign wen_o[g]   = bus[g].sram_we_n;
    assign dqoe_o[g]  = bus[g].sram_dq_oe;
    assign rdata_o[g] = bus[g].cpu_rdata;
    assign dqout_o[g] = bus[g].sram_dq_out;
    assign saddr_o[g] = bus[g].sram_addr;
    assign mmua_o[g]  = bus[g].mmu_addr;
`ifdef MEMCTL_BYTE_LANES_EN
    assign bus[g].cpu_be = be_i[g];
    assign ub_o[g] = bus[g].sram_ub_n;
    assign lb_o[g] = bus[g].sram_lb_n;
`endif
  end

  // Issues one request on instance k and counts strobe cycles until ack (bounded).
  task automatic run_txn(input int k, input logic w, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] din,
                         output int ack_at, output int ce_cnt, output int oe_cnt,
                         output int we_cnt, output int dqoe_cnt, output int lb_cnt,
                         output int ub_cnt, output int bad_addr, output int bad_dq);
    logic [17:0] pa;
    pa = xlate(a);
    ack_at = -1; ce_cnt = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    lb_cnt = 0; ub_cnt = 0; bad_addr = 0; bad_dq = 0;
    @(negedge clk);
    we_i[k] = w; addr_i[k] = a; wdata_i[k] = wd; din_i[k] = din; req_i[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_i[k] = 1'b0;
    for (int n = 1; n <= 40 && ack_at < 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (!ce_o[k]) ce_cnt++;
      if (!oe_o[k]) oe_cnt++;
      if (!wen_o[k]) we_cnt++;
      if (dqoe_o[k]) dqoe_cnt++;
`ifdef MEMCTL_BYTE_LANES_EN
      if (!lb_o[k]) lb_cnt++;
      if (!ub_o[k]) ub_cnt++;
`endif
      if (!ce_o[k] && saddr_o[k] !== pa) bad_addr++;
      if (!wen_o[k] && dqout_o[k] !== wd) bad_dq++;
      if (ack_o[k] === 1'b1) ack_at = n;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      req_i[k] = 1'b0; we_i[k] = 1'b0; addr_i[k] = 16'h0000;
      wdata_i[k] = 16'h0000; din_i[k] = 16'h0000;
`ifdef MEMCTL_BYTE_LANES_EN
      be_i[k] = 2'b11;
`endif
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if ({ack_o[0], busy_o[0], dqoe_o[0]} !== 3'b000) begin
      miscompares++; $display("FAIL reset_ack_busy_oe: got %b expected 000", {ack_o[0], busy_o[0], dqoe_o[0]}); end
    vectors++; if ({ce_o[0], oe_o[0], wen_o[0]} !== 3'b111) begin
      miscompares++; $display("FAIL reset_strobes: got %b expected 111", {ce_o[0], oe_o[0], wen_o[0]}); end
    vectors++; if ({saddr_o[0], dqout_o[0], rdata_o[0]} !== 50'd0) begin
      miscompares++; $display("FAIL reset_data: addr %h dq %h rdata %h expected all 0", saddr_o[0], dqout_o[0], rdata_o[0]); end
    rst_n = 1'b1;
    addr_i[0] = 16'h1234;
    #1;
    vectors++; if (mmua_o[0] !== 16'h1234) begin
      miscompares++; $display("FAIL idle_mmu_addr: got %h expected 1234", mmua_o[0]); end
  endtask

  task automatic test_read();
    int ack_at, ce, oe, we, dqoe, lb, ub, ba, bd;
    run_txn(0, 1'b0, 16'h0805, 16'h0000, 16'hBEEF, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 3) begin miscompares++; $display("FAIL read_ack_cycle: got %0d expected 3", ack_at); end
    vectors++; if (oe !== 2 || ce !== 2) begin miscompares++; $display("FAIL read_strobe_width: oe %0d ce %0d expected 2", oe, ce); end
    vectors++; if (we !== 0 || dqoe !== 0) begin miscompares++; $display("FAIL read_no_drive: we %0d dqoe %0d expected 0", we, dqoe); end
    vectors++; if (ba !== 0 || saddr_o[0] !== 18'h12805) begin
      miscompares++; $display("FAIL read_addr: got %h bad %0d expected 12805", saddr_o[0], ba); end
    vectors++; if (rdata_o[0] !== 16'hBEEF) begin miscompares++; $display("FAIL read_data: got %h expected beef", rdata_o[0]); end
  endtask

  task automatic test_write();
    int ack_at, ce, oe, we, dqoe, lb, ub, ba, bd;
    run_txn(0, 1'b1, 16'hFFFF, 16'hA55A, 16'h0F0F, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 3) begin miscompares++; $display("FAIL write_ack_cycle: got %0d expected 3", ack_at); end
    vectors++; if (we !== 2 || dqoe !== 2 || oe !== 0) begin
      miscompares++; $display("FAIL write_strobes: we %0d dqoe %0d oe %0d expected 2 2 0", we, dqoe, oe); end
    vectors++; if (ba !== 0 || bd !== 0 || saddr_o[0] !== 18'h3FFFF || dqout_o[0] !== 16'hA55A) begin
      miscompares++; $display("FAIL write_addr_data: addr %h dq %h expected 3ffff a55a", saddr_o[0], dqout_o[0]); end
    vectors++; if (rdata_o[0] !== 16'hBEEF) begin miscompares++; $display("FAIL write_keeps_rdata: got %h expected beef", rdata_o[0]); end
  endtask

  task automatic test_wait_states();
    int ack_at, ce, oe, we, dqoe, lb, ub, ba, bd;
    run_txn(1, 1'b0, 16'h2010, 16'h0000, 16'h1357, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 2 || oe !== 1) begin
      miscompares++; $display("FAIL ws0_timing: ack %0d oe %0d expected 2 1", ack_at, oe); end
    vectors++; if (rdata_o[1] !== 16'h1357 || ba !== 0) begin
      miscompares++; $display("FAIL ws0_data: got %h bad addr %0d expected 1357", rdata_o[1], ba); end
    run_txn(2, 1'b1, 16'h0805, 16'hC3C3, 16'h0000, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 17 || we !== 16 || ce !== 16) begin
      miscompares++; $display("FAIL ws15_timing: ack %0d we %0d ce %0d expected 17 16 16", ack_at, we, ce); end
    vectors++; if (ba !== 0 || bd !== 0 || saddr_o[2] !== 18'h12805) begin
      miscompares++; $display("FAIL ws15_addr: got %h expected 12805", saddr_o[2]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    we_i[0] = 1'b0; addr_i[0] = 16'h0100; din_i[0] = 16'h2468; req_i[0] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++; if (ack_o[0] !== (n % 5 == 3)) begin
        miscompares++; $display("FAIL b2b_ack n=%0d: got %b expected %b", n, ack_o[0], (n % 5 == 3)); end
      vectors++; if (busy_o[0] !== (n % 5 != 4)) begin
        miscompares++; $display("FAIL b2b_busy n=%0d: got %b expected %b", n, busy_o[0], (n % 5 != 4)); end
    end
    req_i[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (busy_o[0] !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: busy %b expected 0", busy_o[0]); end
  endtask

  task automatic test_reset_mid_access();
    int ack_at, ce, oe, we, dqoe, lb, ub, ba, bd;
    int acks;
    @(negedge clk);
    we_i[0] = 1'b1; addr_i[0] = 16'h0805; wdata_i[0] = 16'h5A5A; req_i[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_i[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (wen_o[0] !== 1'b0) begin miscompares++; $display("FAIL rst_pre_we: got %b expected 0", wen_o[0]); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({wen_o[0], ce_o[0], dqoe_o[0], busy_o[0]} !== 4'b1100) begin
      miscompares++; $display("FAIL rst_release: we ce dqoe busy %b expected 1100", {wen_o[0], ce_o[0], dqoe_o[0], busy_o[0]}); end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack_o[0] !== 1'b0) acks++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ack_o[0] !== 1'b0) acks++;
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL rst_no_ack: got %0d acks expected 0", acks); end
    run_txn(0, 1'b0, 16'h0805, 16'h0000, 16'h7777, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 3 || rdata_o[0] !== 16'h7777) begin
      miscompares++; $display("FAIL rst_recover: ack %0d rdata %h expected 3 7777", ack_at, rdata_o[0]); end
  endtask

`ifdef MEMCTL_BYTE_LANES_EN
  task automatic test_byte_lanes();
    int ack_at, ce, oe, we, dqoe, lb, ub, ba, bd;
    be_i[0] = 2'b01;
    run_txn(0, 1'b0, 16'h0805, 16'h0000, 16'h1234, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (lb !== 2 || ub !== 0) begin miscompares++; $display("FAIL be01_lanes: lb %0d ub %0d expected 2 0", lb, ub); end
    vectors++; if (rdata_o[0] !== 16'h0034 || ack_at !== 3) begin
      miscompares++; $display("FAIL be01_data: rdata %h ack %0d expected 0034 3", rdata_o[0], ack_at); end
    be_i[0] = 2'b00;
    run_txn(0, 1'b0, 16'h0805, 16'h0000, 16'h5678, ack_at, ce, oe, we, dqoe, lb, ub, ba, bd);
    vectors++; if (ack_at !== 3 || ce !== 0 || oe !== 0 || we !== 0) begin
      miscompares++; $display("FAIL be00_handshake: ack %0d ce %0d oe %0d we %0d expected 3 0 0 0", ack_at, ce, oe, we); end
    be_i[0] = 2'b11;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEMCTL_BYTE_LANES_EN
    test_byte_lanes();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
